// File: rtl/hash_round_sequencer.sv
// rtl/hash_round_sequencer.sv - sequencer feeding the hash datapath's 4:1 operand-select stage
//
// Collects four message words over a valid/ready input stream and holds them
// on Word0..Word3, which drive data inputs 0..3 of the downstream selector.
// Sel is stepped 0..3 for a latched number of passes, with the held words
// rotated by one position after each pass. Done pulses for one cycle when the
// sequence ends.
//
// Ports:
//   Clk_i          rising-edge clock
//   Reset_n_i      synchronous active-low reset
//   InValid_i      InData_i holds a valid word
//   InReady_o      block accepts a word this cycle (LOAD state)
//   InData_i       message word, N bits
//   NumRounds_i    pass count, sampled with the 4th accepted word
//   Word0_o..3_o   held words, to selector data inputs 0..3
//   Sel_o          2-bit selector control
//   OutValid_o     Sel_o/Word*_o form a valid beat (RUN state)
//   OutReady_i     downstream consumes the beat
//   Round_o        index of the current pass, from 0
//   Done_o         one-cycle pulse at the end of the sequence
module hash_round_sequencer #(
    parameter int N = 32,
    parameter int R = 4
) (
    input  logic         Clk_i,
    input  logic         Reset_n_i,
    input  logic         InValid_i,
    output logic         InReady_o,
    input  logic [N-1:0] InData_i,
    input  logic [R-1:0] NumRounds_i,
    output logic [N-1:0] Word0_o,
    output logic [N-1:0] Word1_o,
    output logic [N-1:0] Word2_o,
    output logic [N-1:0] Word3_o,
    output logic [1:0]   Sel_o,
    output logic         OutValid_o,
    input  logic         OutReady_i,
    output logic [R-1:0] Round_o,
    output logic         Done_o
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [N-1:0] word_q [4];
    logic [N-1:0] word_d [4];
    logic [1:0]   sel_q, sel_d;
    logic [R-1:0] round_q, round_d;
    logic [R-1:0] rounds_q, rounds_d;

    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            state_q  <= S_LOAD;
            cnt_q    <= 2'd0;
            sel_q    <= 2'd0;
            round_q  <= '0;
            rounds_q <= '0;
            for (int i = 0; i < 4; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            round_q  <= round_d;
            rounds_q <= rounds_d;
            for (int i = 0; i < 4; i++) begin
                word_q[i] <= word_d[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        round_d  = round_q;
        rounds_d = rounds_q;
        for (int i = 0; i < 4; i++) begin
            word_d[i] = word_q[i];
        end

        // Handshake signals are pure state decodes so they never glitch
        // with the data inputs.
        InReady_o  = (state_q == S_LOAD);
        OutValid_o = (state_q == S_RUN);
        Done_o     = (state_q == S_DONE);

        case (state_q)
            S_LOAD: begin
                if (InValid_i) begin
                    word_d[cnt_q] = InData_i;
                    cnt_d         = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        rounds_d = NumRounds_i;
                        cnt_d    = 2'd0;
                        sel_d    = 2'd0;
                        round_d  = '0;
                        state_d  = (NumRounds_i == '0) ? S_DONE : S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (OutReady_i) begin
                    if (sel_q != 2'd3) begin
                        sel_d = sel_q + 2'd1;
                    end else begin
                        // End of pass: shift every word one selector input down.
                        sel_d     = 2'd0;
                        word_d[0] = word_q[1];
                        word_d[1] = word_q[2];
                        word_d[2] = word_q[3];
                        word_d[3] = word_q[0];
                        // Round stays on the last pass index while Done is shown.
                        if ((round_q + R'(1)) == rounds_q) begin
                            state_d = S_DONE;
                        end else begin
                            round_d = round_q + R'(1);
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_LOAD;
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    assign Word0_o = word_q[0];
    assign Word1_o = word_q[1];
    assign Word2_o = word_q[2];
    assign Word3_o = word_q[3];
    assign Sel_o   = sel_q;
    assign Round_o = round_q;

endmodule

// File: tb/tb_hash_round_sequencer.sv
// tb/tb_hash_round_sequencer.sv - scoreboard bench for hash_round_sequencer
module tb_hash_round_sequencer;

    logic        Clk;
    logic        Reset_n;
    logic        InValid;
    logic        InReady;
    logic [31:0] InData;
    logic [3:0]  NumRounds;
    logic [31:0] Word0, Word1, Word2, Word3;
    logic [1:0]  Sel;
    logic        OutValid;
    logic        OutReady;
    logic [3:0]  Round;
    logic        Done;

    hash_round_sequencer #(.N(32), .R(4)) dut (
        .Clk_i       (Clk),
        .Reset_n_i   (Reset_n),
        .InValid_i   (InValid),
        .InReady_o   (InReady),
        .InData_i    (InData),
        .NumRounds_i (NumRounds),
        .Word0_o     (Word0),
        .Word1_o     (Word1),
        .Word2_o     (Word2),
        .Word3_o     (Word3),
        .Sel_o       (Sel),
        .OutValid_o  (OutValid),
        .OutReady_i  (OutReady),
        .Round_o     (Round),
        .Done_o      (Done)
    );

    typedef struct packed {
        logic [1:0]   sel;
        logic [3:0]   round;
        logic [127:0] words;
    } beat_t;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [127:0] words;
    } done_t;

    beat_t beat_q [$];
    done_t done_q [$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int acc_cyc;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a beat or Done.
    always @(negedge Clk) begin
        if (OutValid) begin
            chk("in_ready_low_in_run", {159'd0, InReady}, 160'd0);
        end
        if (OutValid && OutReady) begin
            if (beat_q.size() == 0) begin
                chk("unexpected_beat", {158'd0, Sel}, {160{1'b1}});
            end else begin
                beat_t e;
                e = beat_q.pop_front();
                chk("beat", {26'd0, Sel, Round, Word0, Word1, Word2, Word3}, {26'd0, e});
            end
        end
        if (Done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", {159'd0, Done}, 160'd0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                chk("done", {cyc[31:0], Word0, Word1, Word2, Word3}, d);
                chk("done_outvalid_low", {159'd0, OutValid}, 160'd0);
            end
        end
    end

    task automatic load4(input logic [31:0] w [4], input logic [3:0] nr, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                InValid = 1'b0;
                InData  = 32'hDEADBEEF;
                @(posedge Clk); #1;
            end
            InValid   = 1'b1;
            InData    = w[i];
            NumRounds = (i == 3) ? nr : 4'hF;
            chk("in_ready_load", {159'd0, InReady}, 160'd1);
            @(posedge Clk); #1;
            InValid = 1'b0;
        end
        // Changing NumRounds after the 4th word must not affect the run.
        NumRounds = 4'h7;
        acc_cyc   = cyc;
    endtask

    task automatic push_expect(input logic [31:0] w [4], input int nr, input int stall);
        logic [31:0] m [4];
        logic [31:0] t;
        beat_t b;
        done_t d;
        for (int i = 0; i < 4; i++) m[i] = w[i];
        for (int r = 0; r < nr; r++) begin
            for (int s = 0; s < 4; s++) begin
                b.sel   = s[1:0];
                b.round = r[3:0];
                b.words = {m[0], m[1], m[2], m[3]};
                beat_q.push_back(b);
            end
            t = m[0]; m[0] = m[1]; m[1] = m[2]; m[2] = m[3]; m[3] = t;
        end
        d.cyc   = 32'(acc_cyc + 4 * nr + stall);
        d.words = {m[0], m[1], m[2], m[3]};
        done_q.push_back(d);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((beat_q.size() != 0 || done_q.size() != 0) && n < 300) begin
            @(posedge Clk); #1;
            n++;
        end
        if (beat_q.size() != 0 || done_q.size() != 0) begin
            chk({name, "_timeout"}, 160'(beat_q.size() + done_q.size()), 160'd0);
            beat_q.delete();
            done_q.delete();
        end
        // Cycle after Done: back in LOAD.
        chk({name, "_in_ready_after_done"}, {159'd0, InReady}, 160'd1);
    endtask

    logic [31:0] W [4];
    logic [31:0] V [4];

    initial begin
        Reset_n   = 1'b0;
        InValid   = 1'b0;
        InData    = '0;
        NumRounds = '0;
        OutReady  = 1'b1;
        W = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        V = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};

        repeat (2) @(posedge Clk);
        #1;
        chk("reset_outputs", {19'd0, Word0, Word1, Word2, Word3, Sel, Round, OutValid, Done, InReady},
            {19'd0, 128'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1});
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        chk("in_ready_after_reset", {159'd0, InReady}, 160'd1);

        // 1: single pass
        load4(W, 4'd1, 1'b0);
        push_expect(W, 1, 0);
        wait_idle("t1");

        // 2: two passes
        load4(W, 4'd2, 1'b0);
        push_expect(W, 2, 0);
        wait_idle("t2");

        // 3: three-cycle stall at Sel=2
        load4(V, 4'd1, 1'b0);
        push_expect(V, 1, 3);
        @(posedge Clk); @(posedge Clk); #1;
        OutReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("stall_hold", {157'd0, Sel, OutValid}, {157'd0, 2'd2, 1'b1});
            @(posedge Clk); #1;
        end
        OutReady = 1'b1;
        wait_idle("t3");

        // 4: zero passes
        load4(V, 4'd0, 1'b0);
        push_expect(V, 0, 0);
        wait_idle("t4");

        // 5: InValid gaps in LOAD, InValid asserted during RUN
        load4(V, 4'd3, 1'b1);
        push_expect(V, 3, 0);
        InValid = 1'b1;
        InData  = 32'hBAD0BAD0;
        repeat (3) @(posedge Clk);
        #1;
        InValid = 1'b0;
        wait_idle("t5");

        // 6: reset mid-run at Sel=1, then a fresh load
        load4(W, 4'd1, 1'b0);
        begin
            beat_t b;
            b.sel   = 2'd0;
            b.round = 4'd0;
            b.words = {W[0], W[1], W[2], W[3]};
            beat_q.push_back(b);
        end
        @(posedge Clk); #1;
        OutReady = 1'b0;
        Reset_n  = 1'b0;
        @(posedge Clk); #1;
        Reset_n  = 1'b1;
        chk("reset_mid_run", {19'd0, Word0, Word1, Word2, Word3, Sel, Round, OutValid, Done, InReady},
            {19'd0, 128'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1});
        chk("beat_queue_after_reset", 160'(beat_q.size()), 160'd0);
        repeat (3) @(posedge Clk);
        #1;
        OutReady = 1'b1;
        load4(V, 4'd1, 1'b0);
        push_expect(V, 1, 0);
        wait_idle("t6");

        repeat (2) @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hash_round_sequencer.md
Name: hash_round_sequencer

Overview:
- Sequential front end for the hash datapath's 4:1 operand-select stage.
- Accepts four N-bit message words over a valid/ready input stream and holds them in registers.
- Holds each word on an output that feeds data inputs 0..3 of the downstream 4:1 N-bit selector.
- Drives the 2-bit select through 0,1,2,3 for a programmable number of passes, rotating the held words after each pass, then pulses Done.

Parameters:
- N, 32, width of each message word and of Word0..Word3.
- R, 4, width of NumRounds and Round (maximum 2^R-1 passes).

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  synchronous active-low reset.
- InValid  input  1  InData holds a valid word.
- InReady  output  1  block accepts a word this cycle.
- InData  input  N  message word.
- NumRounds  input  R  pass count, sampled when the 4th word is accepted.
- Word0  output  N  held word 0, to selector data input 0.
- Word1  output  N  held word 1, to selector data input 1.
- Word2  output  N  held word 2, to selector data input 2.
- Word3  output  N  held word 3, to selector data input 3.
- Sel  output  2  selector control.
- OutValid  output  1  Sel/Word* form a valid beat.
- OutReady  input  1  downstream consumes the beat.
- Round  output  R  index of the current pass, starting at 0.
- Done  output  1  one-cycle pulse when the sequence completes.

Behaviour:
- Clock and reset: single clock Clk; Reset_n is synchronous and active-low.
- Reset: sampled on the rising edge with Reset_n=0. Forces state=LOAD, load count=0, Word0..3=0, Sel=0, Round=0, OutValid=0, Done=0, latched rounds=0.
- Reset priority and outputs: reset overrides all other activity, including mid-LOAD and mid-RUN; no Done is emitted. InReady is decoded from state, so it is 1 from the first edge after reset.
- LOAD state:
  - InReady=1, OutValid=0.
  - A word is accepted on an edge with InValid&InReady. It is written to Word[load count], then load count increments.
  - On acceptance of the 4th word (count=3):
    - Latch NumRounds, clear count, set Sel=0 and Round=0.
    - If NumRounds=0, go to DONE; otherwise go to RUN.
- RUN state:
  - InReady=0; InValid is ignored and the Word registers hold.
  - OutValid=1. A beat completes on an edge with OutValid&OutReady. With OutReady=0, Sel, Round and Word* hold.
  - On a completed beat with Sel<3: Sel increments.
  - On a completed beat with Sel=3 (end of pass):
    - Sel wraps to 0.
    - Words rotate: Word0<=Word1, Word1<=Word2, Word2<=Word3, Word3<=Word0.
    - If Round+1 equals the latched rounds, go to DONE with Round unchanged. Otherwise Round increments.
- DONE state: lasts exactly one cycle.
  - Done=1, OutValid=0, InReady=0.
  - Next state is LOAD; Done returns to 0.
- Throughput and latency:
  - A pass with OutReady held at 1 takes 4 cycles.
  - Done is asserted the cycle after the final beat completes.
  - Total time from the 4th word accepted to Done is 4*NumRounds+1 cycles, or 1 cycle when NumRounds=0.
- Arithmetic: Round and the latched rounds are R-bit unsigned with no overflow. Round reaches at most latched rounds minus 1.

Test Plan:
1. Reset, then load 0x11111111, 0x22222222, 0x33333333, 0x44444444 with NumRounds=1 and OutReady=1 -> Sel 0,1,2,3 on 4 consecutive OutValid cycles with Word0..3 unchanged. Next cycle Done=1 and Word0..3 = 0x22222222, 0x33333333, 0x44444444, 0x11111111. The cycle after, InReady=1.
2. Same words with NumRounds=2 -> Round=0 for beats 1-4 and Round=1 for beats 5-8. During pass 2, Word0 reads 0x22222222. Done pulses after beat 8, with Word0=0x33333333 at that point.
3. NumRounds=1 with OutReady=0 for 3 cycles at Sel=2 -> Sel stays at 2 and OutValid stays at 1 throughout. Sel advances to 3 only after OutReady=1; Done is delayed by exactly 3 cycles.
4. NumRounds=0 -> no OutValid beats; Done=1 on the cycle after the 4th word is accepted.
5. InValid gaps during LOAD -> count advances only on handshake cycles. InValid=1 while in RUN -> InReady=0 and the Word registers are unchanged.
6. Reset_n=0 for one edge at Sel=1 during Round 0 -> next cycle all outputs are at reset values, state=LOAD and no Done pulse. A fresh 4-word load then restarts at Sel=0.
